// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller for the M stage of the 5-stage MIPS core.
// It holds SR, Cause, EPC and PRId, services mfc0/mtc0, and raises the flush request with the return PC.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID     = 32'h2022_0007,
  parameter logic [31:0] SR_WMASK = 32'h0000_FC03
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_in,
  output logic [31:0] cp0_out,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] epc
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [31:0] sr_q, sr_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic int_pend;
  logic exc_pend;

  // Requests are gated by reset so the pipeline never sees a flush while reset is held.
  always_comb begin
    int_pend = (|(hw_int & sr_q[15:10])) & sr_q[0] & ~sr_q[1];
    exc_pend = (exc_code_in != 5'd0) & ~sr_q[1];
    req      = ~reset & (int_pend | exc_pend);
  end

  always_comb begin
    sr_d       = sr_q;
    bd_d       = bd_q;
    ip_d       = hw_int;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (req) begin
      sr_d[1]    = 1'b1;
      bd_d       = bd_in;
      exc_code_d = int_pend ? 5'd0 : exc_code_in;
      epc_d      = bd_in ? (vpc - 32'd4) : vpc;
    end else begin
      // eret owns SR this cycle; an SR write from mtc0 is dropped, an EPC write still lands.
      if (exl_clr) begin
        sr_d[1] = 1'b0;
      end else if (en && (cp0_addr == ADDR_SR)) begin
        sr_d = (sr_q & ~SR_WMASK) | (cp0_in & SR_WMASK);
      end
      if (en && (cp0_addr == ADDR_EPC)) begin
        epc_d = {cp0_in[31:2], 2'b00};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q       <= 32'd0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      sr_q       <= sr_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    cp0_out = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_out = sr_q;
      ADDR_CAUSE: cp0_out = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
      ADDR_EPC:   cp0_out = epc_q;
      ADDR_PRID:  cp0_out = PRID;
      default:    cp0_out = 32'd0;
    endcase
  end

  assign epc = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: a word-array model of the CP0 register file predicts req/epc/cp0_out.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_in;
  logic [31:0] cp0_out;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic        req;
  logic [31:0] epc;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .en(en), .cp0_addr(cp0_addr), .cp0_in(cp0_in),
    .cp0_out(cp0_out), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
    .hw_int(hw_int), .exl_clr(exl_clr), .req(req), .epc(epc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] epc;
    logic [31:0] dout;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: the architectural CP0 register file as 32 words.
  logic [31:0] m_regs [0:31];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  function automatic logic m_int(input logic [5:0] hw);
    logic [31:0] sr = m_regs[12];
    return ((hw & sr[15:10]) != 6'd0) && sr[0] && !sr[1];
  endfunction

  function automatic logic m_req(input logic [5:0] hw, input logic [4:0] exc);
    logic [31:0] sr = m_regs[12];
    return m_int(hw) || ((exc != 5'd0) && !sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd12 || a == 5'd13 || a == 5'd14) return m_regs[a];
    if (a == 5'd15) return 32'h2022_0007;
    return 32'd0;
  endfunction

  task automatic model_step(input logic e, input logic [4:0] a, input logic [31:0] d,
                            input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                            input logic [5:0] hw, input logic ex);
    logic [31:0] sr, cause, epcv;
    logic        take, intr;
    sr    = m_regs[12];
    cause = m_regs[13];
    epcv  = m_regs[14];
    take  = m_req(hw, exc);
    intr  = m_int(hw);
    cause[15:10] = hw;
    if (take) begin
      sr[1]       = 1'b1;
      cause[31]   = bd;
      cause[6:2]  = intr ? 5'd0 : exc;
      epcv        = bd ? pc - 32'd4 : pc;
    end else begin
      if (ex) sr[1] = 1'b0;
      else if (e && a == 5'd12) sr = (sr & ~32'h0000_FC03) | (d & 32'h0000_FC03);
      if (e && a == 5'd14) epcv = {d[31:2], 2'b00};
    end
    m_regs[12] = sr;
    m_regs[13] = cause;
    m_regs[14] = epcv;
  endtask

  // Called just after a rising edge: apply inputs, predict, advance one edge.
  task automatic drive(input logic e, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                       input logic [5:0] hw, input logic ex);
    exp_t x;
    en = e; cp0_addr = a; cp0_in = d; vpc = pc; bd_in = bd;
    exc_code_in = exc; hw_int = hw; exl_clr = ex;
    x.req  = m_req(hw, exc);
    x.epc  = m_regs[14];
    x.dout = m_read(a);
    sb_q.push_back(x);
    @(posedge clk);
    model_step(e, a, d, pc, bd, exc, hw, ex);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [5:0] hw);
    drive(1'b0, a, 32'd0, 32'h0000_5000, 1'b0, 5'd0, hw, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle, so compare one prediction per falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t x;
      x = sb_q.pop_front();
      check("req", {31'd0, req}, {31'd0, x.req});
      check("epc", epc, x.epc);
      check("cp0_out", cp0_out, x.dout);
    end
  end

  initial begin
    logic [4:0] addr_tbl [0:4];
    logic [4:0] ra;
    reset = 1'b1; en = 1'b0; cp0_addr = 5'd0; cp0_in = 32'd0; vpc = 32'd0;
    bd_in = 1'b0; exc_code_in = 5'd5; hw_int = 6'h3F; exl_clr = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("req_in_reset", {31'd0, req}, 32'd0);
    check("epc_in_reset", epc, 32'd0);
    exc_code_in = 5'd0;
    reset = 1'b0;

    rd(5'd13, 6'h3F);
    rd(5'd13, 6'h3F);
    check("cause_ip_after_reset", m_regs[13], 32'h0000_FC00);
    drive(1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    rd(5'd12, 6'd0);
    drive(1'b1, 5'd14, 32'h0000_3007, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    rd(5'd14, 6'd0);
    rd(5'd15, 6'd0);
    rd(5'd7, 6'd0);

    // Interrupt in a delay slot.
    drive(1'b1, 5'd12, 32'h0000_0401, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    drive(1'b0, 5'd13, 32'h0, 32'h0000_3010, 1'b1, 5'd0, 6'b000001, 1'b0);
    rd(5'd13, 6'b000001);
    rd(5'd12, 6'd0);
    drive(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    rd(5'd12, 6'd0);

    // Exception with a masked interrupt line active.
    drive(1'b0, 5'd13, 32'h0, 32'h0000_3020, 1'b0, 5'd10, 6'b000010, 1'b0);
    rd(5'd13, 6'b000010);
    drive(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);

    // Exception suppresses a simultaneous EPC write.
    drive(1'b1, 5'd14, 32'h1234_5678, 32'h0000_4000, 1'b0, 5'd4, 6'd0, 1'b0);
    rd(5'd14, 6'd0);
    check("epc_write_suppressed", m_regs[14], 32'h0000_4000);

    // eret together with SR and EPC writes.
    drive(1'b1, 5'd12, 32'h0000_0000, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    rd(5'd12, 6'd0);
    drive(1'b1, 5'd12, 32'h0000_0403, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
    drive(1'b1, 5'd14, 32'h0000_6006, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
    rd(5'd14, 6'd0);
    rd(5'd12, 6'd0);

    // Pending interrupt, then reset asserted mid-cycle.
    hw_int = 6'b000001; exc_code_in = 5'd0; en = 1'b0; exl_clr = 1'b0;
    #1;
    check("req_before_async_reset", {31'd0, req}, {31'd0, m_req(6'b000001, 5'd0)});
    reset = 1'b1;
    #1;
    check("req_async_reset", {31'd0, req}, 32'd0);
    check("epc_async_reset", epc, 32'd0);
    model_reset();
    @(posedge clk); #1;
    hw_int = 6'd0;
    reset = 1'b0;
    rd(5'd12, 6'd0);
    rd(5'd13, 6'd0);

    // Randomized traffic.
    addr_tbl[0] = 5'd12; addr_tbl[1] = 5'd13; addr_tbl[2] = 5'd14;
    addr_tbl[3] = 5'd15; addr_tbl[4] = 5'd0;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      ra = ($urandom_range(0, 5) == 5) ? 5'($urandom_range(0, 31)) : addr_tbl[$urandom_range(0, 4)];
      d  = $urandom;
      if ($urandom_range(0, 1) == 1) d[0] = 1'b1;
      drive(($urandom_range(0, 2) == 0), ra, d, {$urandom, 2'b00} >> 2 << 2,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
            ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
            ($urandom_range(0, 3) == 0));
    end

    en = 1'b0; exl_clr = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0;
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller for the 5-stage MIPS core, placed at the M stage.
- Holds the SR, Cause, EPC and PRId registers, and services mfc0/mtc0.
- Detects interrupts and synchronous exceptions. Drives the pipeline-flush request and the saved return PC.
- Its req and epc outputs are consumed by the next-PC selector: req forces a fetch from the handler, and eret fetches from epc.

Parameters:
PRID, 32'h2022_0007, constant value read from register 15.
SR_WMASK, 32'h0000_FC03, writable bits of SR (IM[15:10], EXL[1], IE[0]).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  mtc0 write enable (M stage)
cp0_addr  input  5  register number for mfc0/mtc0
cp0_in  input  32  mtc0 write data
cp0_out  output  32  mfc0 read data (combinational)
vpc  input  32  PC of the M-stage instruction (or of the bubble holding its slot)
bd_in  input  1  M-stage instruction is in a branch delay slot
exc_code_in  input  5  M-stage exception code, 0 = none
hw_int  input  6  external interrupt lines, level-sensitive
exl_clr  input  1  eret in M stage
req  output  1  exception/interrupt taken this cycle (combinational)
epc  output  32  current EPC register value

Behaviour:
- Reset, asynchronous and active-high:
  - SR = 0, Cause = 0, EPC = 0.
  - req = 0 and epc = 0 while reset is held.
- Register map:
  - 12 = SR.
  - 13 = Cause: BD[31], IP[15:10], ExcCode[6:2].
  - 14 = EPC.
  - 15 = PRId.
  - Any other address reads 0. Writes to addresses other than 12 and 14 are ignored.
- Pending conditions:
  - int_pend = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
  - exc_pend = (exc_code_in != 0) & ~SR.EXL.
  - req = int_pend | exc_pend, computed combinationally from the current registers and inputs.
- Cause.IP[15:10] <= hw_int on every clock edge, unconditionally, including edges where req is asserted.
- Priority on each edge, highest first:
  - (1) req.
  - (2) exl_clr.
  - (3) en write.
  - If req is high, a simultaneous mtc0 write and eret are both suppressed.
- On an edge where req is high:
  - SR.EXL <= 1.
  - Cause.BD <= bd_in.
  - Cause.ExcCode <= int_pend ? 0 : exc_code_in. An interrupt beats a simultaneous exception.
  - EPC <= bd_in ? vpc - 4 : vpc. The subtraction is 32-bit and wraps modulo 2^32.
- exl_clr without req: SR.EXL <= 0 on the edge. Other SR bits are unchanged.
- en without req and without exl_clr:
  - addr 12: SR <= (SR & ~SR_WMASK) | (cp0_in & SR_WMASK).
  - addr 14: EPC <= {cp0_in[31:2], 2'b00}.
- exl_clr and en together, without req: the EXL clear wins for SR. An EPC write in the same cycle still applies.
- mfc0 read data:
  - cp0_out returns register contents before the current edge. There is no write-through bypass.
  - Reads of Cause reflect IP as sampled on the previous edge.
- epc is the registered EPC, available the cycle after capture.
- While SR.EXL = 1, req stays low. There are no nested exceptions.
- Reset asserted mid-handler clears EXL immediately. req deasserts within the same cycle, with no clock needed.
- Latency:
  - req: 0 cycles from inputs.
  - Register updates: 1 edge.

Test Plan:
- Reset release with SR = 0 and hw_int = 6'h3F -> req = 0, epc = 0. Read addr 13 after one edge -> 32'h0000_FC00.
- mtc0 addr 12 with 32'hFFFF_FFFF, then mfc0 12 -> 32'h0000_FC03. Write addr 14 with 32'h0000_3007 -> epc = 32'h0000_3004.
- SR = 32'h0000_0401, hw_int = 6'b000001, vpc = 32'h0000_3010, bd_in = 1:
  - req = 1 in the same cycle.
  - Next cycle: epc = 32'h0000_300C, Cause = 32'h8000_0400 with ExcCode 0, SR.EXL = 1, req = 0.
- exc_code_in = 5'd10 (RI) and a masked interrupt, vpc = 32'h0000_3020, bd_in = 0:
  - req = 1.
  - Next cycle: Cause[6:2] = 10, epc = 32'h0000_3020.
- Same cycle: exc_code_in = 4, en = 1, addr 14, data 32'h1234_5678, vpc = 32'h0000_4000 -> epc = 32'h0000_4000 (the write is suppressed).
- With EXL = 1, pulse exl_clr -> EXL = 0 next cycle. Then assert a pending enabled interrupt -> req = 1. Assert reset mid-cycle -> req = 0 immediately.
